// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential comparator: RISC-V funct3 compare opcodes,
// the FSM state encoding and the signed-mode helper.
package seq_cmp_pkg;

    localparam int CMP_OP_W = 3;

    typedef enum logic [CMP_OP_W-1:0] {
        EQ  = 3'b000,
        NE  = 3'b001,
        LT  = 3'b100,
        GE  = 3'b101,
        LTU = 3'b110,
        GEU = 3'b111
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    function automatic logic is_signed_op(input logic [CMP_OP_W-1:0] op);
        return (op == LT) || (op == GE);
    endfunction

endpackage

// File: rtl/seq_cmp_unit_cmp_chunk.sv
// One CHUNK-wide unsigned slice compare; the top walks these MSB to LSB.
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             chunk_lt,
    output logic             chunk_ne
);

    assign chunk_lt = (a < b);
    assign chunk_ne = (a != b);

endmodule

// File: rtl/seq_cmp_unit.sv
// Multi-cycle comparator covering all RISC-V branch compares plus SLT/SLTU.
// Build option SEQ_CMP_EARLY_EXIT_EN: finish as soon as the first differing chunk is seen.
module seq_cmp_unit
    import seq_cmp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_a,
    input  logic [XLEN-1:0]     in_b,
    input  logic [CMP_OP_W-1:0] in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_res,
    output logic [XLEN-1:0]     out_word
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [XLEN-1:0] MSB_MASK = XLEN'(1) << (XLEN - 1);

    generate
        if ((XLEN % CHUNK) != 0 || CHUNK < 1 || CHUNK > XLEN) begin : g_bad_cfg
            $error("seq_cmp_unit: CHUNK must divide XLEN and lie in 1..XLEN");
        end
    endgenerate

    cmp_state_e            state_q, state_d;
    logic [XLEN-1:0]       a_q, a_d, b_q, b_d;
    logic [CMP_OP_W-1:0]   op_q, op_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  decided_q, decided_d;
    logic                  lt_q, lt_d;

    logic [CHUNK-1:0]      a_chunk, b_chunk;
    logic                  chunk_lt, chunk_ne;
    logic                  accept;

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .chunk_lt (chunk_lt),
        .chunk_ne (chunk_ne)
    );

    // Handshake: a beat moves when valid && ready; DONE can hand off its result
    // and take the next request in the same edge, so no idle bubble is needed.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;

        case (state_q)
            BUSY: begin
                if (!decided_q && chunk_ne) begin
                    decided_d = 1'b1;
                    lt_d      = chunk_lt;
                end
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (idx_q == '0 || (!decided_q && chunk_ne)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`else
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (accept) begin
            a_d       = is_signed_op(in_op) ? (in_a ^ MSB_MASK) : in_a;
            b_d       = is_signed_op(in_op) ? (in_b ^ MSB_MASK) : in_b;
            op_d      = in_op;
            idx_d     = IDX_W'(NCHUNK - 1);
            decided_d = 1'b0;
            lt_d      = 1'b0;
            state_d   = BUSY;
        end
    end

    always_comb begin
        out_res = 1'b0;
        if (state_q == DONE) begin
            case (op_q)
                EQ:       out_res = !decided_q;
                NE:       out_res = decided_q;
                LT, LTU:  out_res = lt_q;
                GE, GEU:  out_res = !lt_q;
                default:  out_res = 1'b0;
            endcase
        end
    end

    assign out_word = XLEN'(out_res);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
        end
    end

endmodule

// File: tb/tb_seq_cmp_unit.sv
// Directed testbench for seq_cmp_unit (XLEN=32, CHUNK=8); expected results and
// latencies are hand-computed, with the latency table following SEQ_CMP_EARLY_EXIT_EN.
module tb_seq_cmp_unit;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int MAX_WAIT = 20;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam int LAT_MSB = 1;
`else
    localparam int LAT_MSB = NCHUNK;
`endif

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_RSV = 3'b010;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic [2:0]      in_op = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_res;
    logic [XLEN-1:0] out_word;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];

    seq_cmp_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_word  (out_word)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for out_valid after the accept edge; returns edges counted.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_res, input int exp_lat);
        int   lat;
        logic e;
        exp_q.push_back(exp_res);
        drive_req(op, a, b);
        wait_result(lat);
        e = exp_q.pop_front();
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_res"}, 64'(out_res), 64'(e));
        check_val({tag, "_word"}, 64'(out_word), 64'(e));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int stale;

        #12;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_res", 64'(out_res), 64'd0);
        check_val("rst_out_word", 64'(out_word), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_req("ltu_1_2",   OP_LTU, 32'h0000_0001, 32'h0000_0002, 1'b1, NCHUNK);
        run_req("lt_min_1",  OP_LT,  32'h8000_0000, 32'h0000_0001, 1'b1, LAT_MSB);
        run_req("lt_max_m1", OP_LT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT_MSB);
        run_req("ge_max_m1", OP_GE,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, LAT_MSB);
        run_req("ltu_max",   OP_LTU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, LAT_MSB);
        run_req("eq_ones",   OP_EQ,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, NCHUNK);
        run_req("ne_ones",   OP_NE,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, NCHUNK);
        run_req("ne_diff",   OP_NE,  32'h1234_0000, 32'h1235_0000, 1'b1, (LAT_MSB == 1) ? 2 : NCHUNK);
        run_req("rsv_op",    OP_RSV, 32'h0000_0005, 32'h0000_0003, 1'b0, NCHUNK);

        // Back-pressure, then a same-edge handoff to the next request.
        drive_req(OP_GEU, 32'h0000_0003, 32'h0000_0002);
        wait_result(lat);
        check_val("geu_lat", 64'(lat), 64'(NCHUNK));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_res", 64'(out_res), 64'd1);
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = OP_EQ;
        in_a      = 32'h0000_0005;
        in_b      = 32'h0000_0006;
        #1;
        check_val("handoff_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_val("handoff_busy", 64'(out_valid), 64'd0);
        wait_result(lat);
        check_val("handoff_lat", 64'(lat), 64'(NCHUNK));
        check_val("handoff_res", 64'(out_res), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two cycles into BUSY must drop the request at once.
        drive_req(OP_LTU, 32'h0000_0001, 32'h0000_0002);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check_val("arst_no_stale", 64'(stale), 64'd0);
        run_req("post_rst", OP_GEU, 32'h0000_0001, 32'h0000_0002, 1'b0, NCHUNK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_cmp_unit.md
Name: seq_cmp_unit

Overview:
- Parametrised multi-cycle integer comparator for the RISC-V ALU/branch path.
- Generalises the single-result combinational set-less-than to all six branch compare modes plus SLT/SLTU, at any XLEN.
- Scans CHUNK bits per cycle from MSB to LSB, so a wide compare meets timing.
- Uses valid/ready handshakes on input and output.

Parameters:
- XLEN, 32, operand width. XLEN % CHUNK must be 0; elaboration error otherwise.
- CHUNK, 8, bits compared per cycle, 1..XLEN. NCHUNK = XLEN/CHUNK.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B.
- in_op  in  3  cmp_op_e, RISC-V funct3 encoding.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_res  out  1  compare outcome.
- out_word  out  XLEN  zero-extended out_res, used as the SLT/SLTU writeback value.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_res=0, out_word=0, internal regs=0.
- States: IDLE, BUSY, DONE.
- Request accept:
  - Accept occurs on in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - At the accept edge, latch a, b and op, set idx=NCHUNK-1, clear decided/lt, and go to BUSY.
- Signed modes (LT, GE):
  - Invert bit XLEN-1 of both operands at latch time.
  - All compares are then unsigned.
- BUSY, each cycle:
  - Compare chunk idx of a and b.
  - If !decided and the chunks differ: set decided=1 and lt=(a_chunk<b_chunk).
  - If idx==0, go to DONE; else decrement idx.
- Latency: out_valid rises exactly NCHUNK edges after the accept edge. With CHUNK==XLEN this is 1 edge.
- Result: eq=!decided.
  - EQ: out_res=eq.
  - NE: out_res=!eq.
  - LT and LTU: out_res=lt.
  - GE and GEU: out_res=!lt.
  - Encodings 2 and 3: out_res=0.
- DONE:
  - out_valid=1; out_res and out_word are held stable while out_ready=0.
  - On out_ready with in_valid: accept the new request in the same edge and go to BUSY.
  - On out_ready without in_valid: go to IDLE.
- in_a, in_b and in_op are ignored outside an accept edge.
- Reset mid-BUSY or mid-DONE: the result is discarded and the unit returns to IDLE immediately. No stale out_valid appears after rst deasserts.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: BUSY goes to DONE on the same edge that sets decided.
  - Latency equals the number of chunks scanned up to and including the first differing chunk, counted from the MSB.
  - Equal operands still take NCHUNK edges.
- Undefined: fixed NCHUNK-edge latency, independent of data.

Decomposition:
- Package seq_cmp_pkg holds:
  - cmp_op_e: EQ=3'b000, NE=3'b001, LT=3'b100, GE=3'b101, LTU=3'b110, GEU=3'b111.
  - CMP_OP_W=3.
  - state enum.
  - Function is_signed_op(op).
- Sub-module cmp_chunk: combinational, parametrised by CHUNK, outputs chunk_lt and chunk_ne.

Test Plan (XLEN=32, CHUNK=8):
1. LTU, a=0x00000001, b=0x00000002 -> out_res=1, out_word=0x00000001, out_valid 4 edges after accept, in both builds.
2. LT, a=0x80000000, b=0x00000001 -> out_res=1. Latency 1 edge with SEQ_CMP_EARLY_EXIT_EN, 4 edges without.
3. LT, a=0x7FFFFFFF, b=0xFFFFFFFF -> out_res=0. Repeat with GE -> out_res=1. Repeat with LTU -> out_res=1.
4. EQ, a=b=0xFFFFFFFF -> out_res=1 after 4 edges in both builds. Repeat with NE -> out_res=0.
5. GEU, a=0x00000003, b=0x00000002, with out_ready held 0 for 3 cycles -> out_valid and out_res=1 stay stable, in_ready=0. Then pulse out_ready with in_valid high for a second request -> it is accepted the same edge, with no idle bubble.
6. Assert rst 2 cycles into BUSY -> out_valid=0 and in_ready=1 asynchronously. No result is emitted after release. The next request completes normally.
